// File: rtl/screen_memory_engine.sv
// Character screen memory: CPU port, registered display port and a fill engine.
// Define SCRMEM_SCROLL_EN to add the hardware scroll-up command.
module screen_memory_engine #(
    parameter int    Abits     = 11,
    parameter int    Dbits     = 3,
    parameter int    COLS      = 40,
    parameter int    ROWS      = 30,
    parameter string INIT_FILE = "screen_memory.txt"
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr,
    input  logic [Abits-1:0] addr,
    input  logic [Dbits-1:0] din,
    output logic [Dbits-1:0] dout,
    input  logic [Abits-1:0] screenAddr,
    output logic [Dbits-1:0] character,
    input  logic             fill_start,
    input  logic [Abits-1:0] fill_base,
    input  logic [Abits:0]   fill_count,
    input  logic [Dbits-1:0] fill_value,
    input  logic             scroll_start,
    output logic             busy,
    output logic             done,
    output logic             wr_dropped
);
    localparam int               DEPTH   = COLS * ROWS;
    localparam logic [Abits:0]   DEPTH_W = (Abits+1)'(DEPTH);
    localparam logic [Abits-1:0] LAST    = Abits'(DEPTH - 1);

`ifdef SCRMEM_SCROLL_EN
    localparam logic [Abits-1:0] COPY_LAST = Abits'(DEPTH - COLS - 1);
    typedef enum logic [1:0] {IDLE, FILL, SCROLL_COPY, SCROLL_CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL} state_t;
    logic unused_scroll;
    assign unused_scroll = scroll_start;
`endif

    logic [Dbits-1:0] mem [DEPTH];

    state_t           state_q;
    logic [Abits-1:0] ptr_q;
    logic [Abits:0]   rem_q;
    logic [Dbits-1:0] val_q;
    logic             busy_q, done_q, drop_q;
    logic [Dbits-1:0] char_q;

    logic             addr_ok, sa_ok, base_ok;
    logic             eng_we;
    logic [Dbits-1:0] eng_data;

    assign addr_ok = {1'b0, addr} < DEPTH_W;
    assign sa_ok   = {1'b0, screenAddr} < DEPTH_W;
    assign base_ok = {1'b0, fill_base} < DEPTH_W;

    assign dout       = addr_ok ? mem[addr] : '0;
    assign character  = char_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign wr_dropped = drop_q;

    always_comb begin
        eng_we   = 1'b0;
        eng_data = val_q;
        case (state_q)
            FILL: eng_we = 1'b1;
`ifdef SCRMEM_SCROLL_EN
            SCROLL_COPY: begin
                eng_we   = 1'b1;
                eng_data = mem[ptr_q + Abits'(COLS)];
            end
            SCROLL_CLEAR: eng_we = 1'b1;
`endif
            default: eng_we = 1'b0;
        endcase
    end

    // Engine and CPU never write together: CPU writes need busy low.
    always_ff @(posedge clock) begin
        if (eng_we && !reset)
            mem[ptr_q] <= eng_data;
        else if (wr && !busy_q && addr_ok)
            mem[addr] <= din;
    end

    always_ff @(posedge clock) begin
        if (reset) char_q <= '0;
        else       char_q <= sa_ok ? mem[screenAddr] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            val_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            drop_q <= wr && busy_q;
            case (state_q)
                IDLE: begin
                    if (fill_start) begin
                        val_q <= fill_value;
                        if (fill_count != '0 && base_ok) begin
                            ptr_q   <= fill_base;
                            rem_q   <= fill_count;
                            state_q <= FILL;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
`ifdef SCRMEM_SCROLL_EN
                    else if (scroll_start) begin
                        val_q   <= fill_value;
                        ptr_q   <= '0;
                        state_q <= SCROLL_COPY;
                        busy_q  <= 1'b1;
                    end
`endif
                end
                FILL: begin
                    ptr_q <= ptr_q + 1'b1;
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == (Abits+1)'(1) || ptr_q == LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`ifdef SCRMEM_SCROLL_EN
                SCROLL_COPY: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == COPY_LAST) state_q <= SCROLL_CLEAR;
                end
                SCROLL_CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_screen_memory_engine.sv
// Directed bench for screen_memory_engine (40x30 screen, 3-bit cells).
// Memory is preloaded through the CPU port: row r holds r mod 8.
module tb_screen_memory_engine;
    logic        clock = 1'b0;
    logic        reset;
    logic        wr;
    logic [10:0] addr;
    logic [2:0]  din;
    logic [2:0]  dout;
    logic [10:0] screenAddr;
    logic [2:0]  character;
    logic        fill_start;
    logic [10:0] fill_base;
    logic [11:0] fill_count;
    logic [2:0]  fill_value;
    logic        scroll_start;
    logic        busy, done, wr_dropped;

    int errors = 0;
    int checks = 0;
    int n;
    int samp [0:15];

    screen_memory_engine #(
        .Abits(11), .Dbits(3), .COLS(40), .ROWS(30), .INIT_FILE("")
    ) dut (
        .clock(clock), .reset(reset), .wr(wr), .addr(addr), .din(din),
        .dout(dout), .screenAddr(screenAddr), .character(character),
        .fill_start(fill_start), .fill_base(fill_base),
        .fill_count(fill_count), .fill_value(fill_value),
        .scroll_start(scroll_start), .busy(busy), .done(done),
        .wr_dropped(wr_dropped)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input int a, input int exp);
        addr = 11'(a);
        #1;
        chk(tag, int'(dout), exp);
    endtask

    task automatic preload;
        wr = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            addr = 11'(i);
            din  = 3'((i / 40) % 8);
            tick();
        end
        wr = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 3000) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; addr = '0; din = '0; screenAddr = '0;
        fill_start = 1'b0; fill_base = '0; fill_count = '0;
        fill_value = '0; scroll_start = 1'b0;
        tick(); tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_drop", int'(wr_dropped), 0);
        chk("rst_char", int'(character), 0);
        reset = 1'b0;

        preload();
        rd("pre_0", 0, 0);
        rd("pre_45", 45, 1);
        rd("pre_399", 399, 1);
        rd("pre_1199", 1199, 5);
        wr = 1'b1; addr = 11'd1200; din = 3'd7;
        tick();
        wr = 1'b0;
        rd("oor_dout", 1200, 0);
        chk("oor_nodrop", int'(wr_dropped), 0);
        screenAddr = 11'd45;
        tick();
        chk("char_45", int'(character), 1);
        screenAddr = 11'd2047;
        tick();
        chk("char_oor", int'(character), 0);

        // fill 100..104 with 5, display watching cell 102
        screenAddr = 11'd102;
        fill_start = 1'b1; fill_base = 11'd100;
        fill_count = 12'd5; fill_value = 3'd5;
        tick();
        fill_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 15) begin
            n++;
            samp[n] = int'(character);
            tick();
        end
        chk("fill5_busy", n, 5);
        chk("fill5_done", int'(done), 1);
        chk("rbw_old", samp[4], 2);
        chk("rbw_new", samp[5], 5);
        tick();
        chk("fill5_done_off", int'(done), 0);
        rd("fill5_99", 99, 2);
        rd("fill5_100", 100, 5);
        rd("fill5_104", 104, 5);
        rd("fill5_105", 105, 2);

        // dropped write and ignored restart during a 20-cell fill
        fill_start = 1'b1; fill_base = 11'd600;
        fill_count = 12'd20; fill_value = 3'd3;
        tick();
        fill_start = 1'b0;
        tick();
        wr = 1'b1; addr = 11'd50; din = 3'd4;
        fill_start = 1'b1; fill_base = 11'd0;
        fill_count = 12'd5; fill_value = 3'd5;
        #1;
        chk("busy_dout", int'(dout), 1);
        tick();
        wr = 1'b0; fill_start = 1'b0;
        chk("drop_pulse", int'(wr_dropped), 1);
        tick();
        chk("drop_off", int'(wr_dropped), 0);
        wait_idle(n);
        chk("fill20_rest", n, 17);
        chk("fill20_done", int'(done), 1);
        rd("drop_50", 50, 1);
        rd("ignored_0", 0, 0);
        rd("fill20_599", 599, 6);
        rd("fill20_600", 600, 3);
        rd("fill20_619", 619, 3);
        rd("fill20_620", 620, 7);

        // range truncated at the last cell
        fill_start = 1'b1; fill_base = 11'd1198;
        fill_count = 12'd10; fill_value = 3'd4;
        tick();
        fill_start = 1'b0;
        wait_idle(n);
        chk("trunc_busy", n, 2);
        chk("trunc_done", int'(done), 1);
        rd("trunc_1197", 1197, 5);
        rd("trunc_1198", 1198, 4);
        rd("trunc_1199", 1199, 4);
        rd("trunc_nowrap", 0, 0);

        // zero count and out-of-range base
        fill_start = 1'b1; fill_base = 11'd10;
        fill_count = 12'd0; fill_value = 3'd7;
        tick();
        fill_start = 1'b0;
        chk("zero_busy", int'(busy), 0);
        chk("zero_done", int'(done), 1);
        tick();
        chk("zero_done_off", int'(done), 0);
        rd("zero_10", 10, 0);
        fill_start = 1'b1; fill_base = 11'd1500; fill_count = 12'd5;
        tick();
        fill_start = 1'b0;
        chk("oorb_busy", int'(busy), 0);
        chk("oorb_done", int'(done), 1);

        // reset aborts a running fill
        fill_start = 1'b1; fill_base = 11'd200;
        fill_count = 12'd40; fill_value = 3'd2;
        tick();
        fill_start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_char", int'(character), 0);
        reset = 1'b0;
        tick();
        chk("abort_nodone", int'(done), 0);
        chk("abort_idle", int'(busy), 0);
        rd("abort_200", 200, 2);
        rd("abort_201", 201, 2);
        rd("abort_202", 202, 5);

`ifdef SCRMEM_SCROLL_EN
        preload();
        scroll_start = 1'b1; fill_value = 3'd0;
        tick();
        scroll_start = 1'b0;
        wait_idle(n);
        chk("scroll_busy", n, 1200);
        chk("scroll_done", int'(done), 1);
        rd("scroll_0", 0, 1);
        rd("scroll_280", 280, 0);
        rd("scroll_1125", 1125, 5);
        rd("scroll_1159", 1159, 5);
        rd("scroll_1160", 1160, 0);
        rd("scroll_1199", 1199, 0);
`else
        scroll_start = 1'b1; fill_value = 3'd0;
        tick();
        scroll_start = 1'b0;
        chk("noscroll_busy", int'(busy), 0);
        chk("noscroll_done", int'(done), 0);
        tick();
        chk("noscroll_busy2", int'(busy), 0);
        rd("noscroll_45", 45, 1);
        rd("noscroll_1160", 1160, 5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
